// File: rtl/core_sub_norm_pipe_pkg.sv
// Shared ppu definitions: default datapath sizes and total-exponent saturation bounds.
package core_sub_norm_pipe_pkg;

   // Default fraction width; the mantissa datapath is 2*MANT_SIZE(+carry) wide.
   localparam int MANT_SIZE_DEF = 14;

   // Default signed total-exponent width.
   localparam int TE_SIZE_DEF = 9;

   // Most negative representable total exponent for a given width.
   function automatic int te_min_f(input int te_size);
      return -(32'sd1 <<< (te_size - 32'sd1));
   endfunction

   // Most positive representable total exponent for a given width.
   function automatic int te_max_f(input int te_size);
      return (32'sd1 <<< (te_size - 32'sd1)) - 32'sd1;
   endfunction

   // Saturation bounds for the default exponent width.
   localparam int TE_MIN = te_min_f(TE_SIZE_DEF);
   localparam int TE_MAX = te_max_f(TE_SIZE_DEF);

endpackage : core_sub_norm_pipe_pkg

// File: rtl/core_sub_norm_pipe_cls.sv
// Leading-bit counter: counts how many bits, starting at the MSB, equal val.
// An input made entirely of val-bits returns NUM_BITS.
module cls #(
   parameter int   NUM_BITS = 8,
   parameter logic val      = 1'b0,
   parameter int   CNT_W    = $clog2(NUM_BITS + 1)
) (
   input  logic [NUM_BITS-1:0] bits_i,
   output logic [CNT_W-1:0]    count_o
);

   logic run_s;

   // Walk from the MSB down, counting matches until the first differing bit.
   always_comb begin
      count_o = '0;
      run_s   = 1'b1;
      for (int i = NUM_BITS - 1; i >= 0; i--) begin
         if (run_s && (bits_i[i] == val)) begin
            count_o = count_o + CNT_W'(1);
         end else begin
            run_s = 1'b0;
         end
      end
   end

endmodule : cls

// File: rtl/core_sub_norm_pipe.sv
// Two-stage normaliser for a subtraction result: S1 captures the operands and
// the leading-zero count, S2 shifts the mantissa, adjusts and saturates the
// total exponent and raises the zero/underflow flags. Valid/ready on both sides.
module core_sub_norm_pipe
   import core_sub_norm_pipe_pkg::*;
#(
   parameter int MANT_SIZE = MANT_SIZE_DEF,
   parameter int TE_SIZE   = TE_SIZE_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2*MANT_SIZE:0]     in_mant,
   input  logic [TE_SIZE-1:0]       in_te_diff,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*MANT_SIZE+1:0]   out_mant,
   output logic [TE_SIZE-1:0]       out_te_diff,
   output logic                     out_zero,
   output logic                     out_underflow
);

   localparam int FW  = 2 * MANT_SIZE;          // fraction field below the carry bit
   localparam int IW  = FW + 1;                 // input mantissa incl. carry
   localparam int OW  = FW + 2;                 // output mantissa
   localparam int LZW = $clog2(FW + 1);         // leading-zero count width
   localparam int DW  = TE_SIZE + 1;            // exponent arithmetic width

   localparam logic signed [DW-1:0] TE_MIN_EXT = DW'(te_min_f(TE_SIZE));

   // Handshake
   logic              s1_adv_s;

   // Stage 1
   logic [LZW-1:0]     cls_cnt_s;
   logic [LZW-1:0]     lz_s;
   logic               s1_valid_q, s1_valid_d;
   logic [IW-1:0]      s1_mant_q,  s1_mant_d;
   logic [TE_SIZE-1:0] s1_te_q,    s1_te_d;
   logic [LZW-1:0]     s1_lz_q,    s1_lz_d;

   // Stage 2
   logic [OW-1:0]        shift_s;
   logic signed [DW-1:0] diff_s;
   logic                 s2_valid_q, s2_valid_d;
   logic [OW-1:0]        s2_mant_q,  s2_mant_d;
   logic [TE_SIZE-1:0]   s2_te_q,    s2_te_d;
   logic                 s2_zero_q,  s2_zero_d;
   logic                 s2_uf_q,    s2_uf_d;

   // S1 may advance whenever S2 is empty or draining; in_ready never looks at in_valid.
   assign s1_adv_s = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv_s;

   cls #(
      .NUM_BITS (FW),
      .val      (1'b0),
      .CNT_W    (LZW)
   ) u_cls (
      .bits_i  (in_mant[FW-1:0]),
      .count_o (cls_cnt_s)
   );

   // An empty fraction field normalises with no shift at all.
   always_comb begin
      if (in_mant[FW-1:0] == {FW{1'b0}}) begin
         lz_s = '0;
      end else begin
         lz_s = cls_cnt_s;
      end
   end

   // S1 next state: load on an input transfer, bubble when ready without valid, else hold.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_mant_d  = s1_mant_q;
      s1_te_d    = s1_te_q;
      s1_lz_d    = s1_lz_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_mant_d = in_mant;
            s1_te_d   = in_te_diff;
            s1_lz_d   = lz_s;
         end else begin
            s1_mant_d = s1_mant_q;
         end
      end else begin
         s1_valid_d = s1_valid_q;
      end
   end

   // S2 datapath: normalising shift and exponent adjustment at one extra bit.
   always_comb begin
      shift_s = {1'b0, s1_mant_q} << s1_lz_q;
      diff_s  = $signed({s1_te_q[TE_SIZE-1], s1_te_q})
              - $signed({{(DW - LZW){1'b0}}, s1_lz_q});
   end

   // S2 next state: capture results when advancing, otherwise hold them stable.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_mant_d  = s2_mant_q;
      s2_te_d    = s2_te_q;
      s2_zero_d  = s2_zero_q;
      s2_uf_d    = s2_uf_q;
      if (s1_adv_s) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            if (s1_mant_q == {IW{1'b0}}) begin
               s2_mant_d = '0;
               s2_te_d   = s1_te_q;
               s2_zero_d = 1'b1;
               s2_uf_d   = 1'b0;
            end else begin
               s2_mant_d = shift_s;
               s2_zero_d = 1'b0;
               if (diff_s < TE_MIN_EXT) begin
                  s2_te_d = TE_MIN_EXT[TE_SIZE-1:0];
                  s2_uf_d = 1'b1;
               end else begin
                  s2_te_d = diff_s[TE_SIZE-1:0];
                  s2_uf_d = 1'b0;
               end
            end
         end else begin
            s2_mant_d = s2_mant_q;
         end
      end else begin
         s2_valid_d = s2_valid_q;
      end
   end

   // Pipeline registers; reset flushes both stages and clears the visible outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_mant_q  <= '0;
         s1_te_q    <= '0;
         s1_lz_q    <= '0;
         s2_valid_q <= 1'b0;
         s2_mant_q  <= '0;
         s2_te_q    <= '0;
         s2_zero_q  <= 1'b0;
         s2_uf_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_mant_q  <= s1_mant_d;
         s1_te_q    <= s1_te_d;
         s1_lz_q    <= s1_lz_d;
         s2_valid_q <= s2_valid_d;
         s2_mant_q  <= s2_mant_d;
         s2_te_q    <= s2_te_d;
         s2_zero_q  <= s2_zero_d;
         s2_uf_q    <= s2_uf_d;
      end
   end

   assign out_valid     = s2_valid_q;
   assign out_mant      = s2_mant_q;
   assign out_te_diff   = s2_te_q;
   assign out_zero      = s2_zero_q;
   assign out_underflow = s2_uf_q;

endmodule : core_sub_norm_pipe

// File: tb/tb_core_sub_norm_pipe.sv
// Scoreboard bench for core_sub_norm_pipe at MANT_SIZE=4, TE_SIZE=6.
module tb_core_sub_norm_pipe;

   localparam int M = 4;
   localparam int T = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2*M:0]  in_mant = '0;
   logic [T-1:0]  in_te_diff = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [2*M+1:0] out_mant;
   logic [T-1:0]  out_te_diff;
   logic          out_zero;
   logic          out_underflow;

   typedef struct packed {
      logic [2*M+1:0] mant;
      logic [T-1:0]   te;
      logic           zero;
      logic           uf;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   bit   rand_mode = 1'b0;
   bit   forced_ready = 1'b1;

   bit             prev_stall = 1'b0;
   logic [2*M+1:0] prev_mant;
   logic [T-1:0]   prev_te;
   logic           prev_zero, prev_uf;

   core_sub_norm_pipe #(.MANT_SIZE(M), .TE_SIZE(T)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_mant       (in_mant),
      .in_te_diff    (in_te_diff),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_mant      (out_mant),
      .out_te_diff   (out_te_diff),
      .out_zero      (out_zero),
      .out_underflow (out_underflow)
   );

   always #5 clk = ~clk;

   // Reference: normalise by doubling until the fraction MSB is set, then saturate.
   function automatic exp_t model(input logic [2*M:0] m, input logic [T-1:0] t);
      exp_t r;
      int   field = int'(m[2*M-1:0]);
      int   mv    = int'(m);
      int   lz    = 0;
      int   tv    = $signed(t);
      if (field != 0) begin
         while (field < (1 << (2*M-1))) begin
            field = field * 2;
            lz++;
         end
      end
      r.mant = (2*M+2)'((mv << lz) % (1 << (2*M+2)));
      tv = tv - lz;
      r.uf = 1'b0;
      if (tv < -(1 << (T-1))) begin
         tv = -(1 << (T-1));
         r.uf = 1'b1;
      end
      r.te = T'(tv);
      r.zero = (mv == 0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Issue one item from posedge+1 alignment; returns at posedge+1 after it is accepted.
   task automatic send(input logic [2*M:0] m, input logic [T-1:0] t);
      int w = 0;
      in_valid = 1'b1;
      in_mant = m;
      in_te_diff = t;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready still %b after %0d cycles", in_ready, w);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) @(negedge clk);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Downstream ready: random in rand_mode, otherwise the level the main sequence asks for.
   always @(posedge clk) begin
      #2;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
   end

   // Stimulus side of the scoreboard: predict every accepted input.
   always @(negedge clk) begin
      if (rst === 1'b0 && in_valid && in_ready) sb.push_back(model(in_mant, in_te_diff));
   end

   // Output monitor: compare each transfer in order and check stall stability.
   always @(negedge clk) begin
      exp_t e;
      if (rst !== 1'b0) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_stable", {out_mant, out_te_diff, out_zero, out_underflow},
                {prev_mant, prev_te, prev_zero, prev_uf});
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: mant=%0h te=%0h with nothing pending", out_mant, out_te_diff);
            end else begin
               e = sb.pop_front();
               chk("result", {out_mant, out_te_diff, out_zero, out_underflow},
                   {e.mant, e.te, e.zero, e.uf});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_mant = out_mant;
         prev_te = out_te_diff;
         prev_zero = out_zero;
         prev_uf = out_underflow;
      end
   end

   initial begin
      logic [2*M:0] rm;
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_mant", 32'(out_mant), 32'd0);
      chk("rst_out_te", 32'(out_te_diff), 32'd0);
      chk("rst_flags", {30'd0, out_zero, out_underflow}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Latency: normal normalisation 0x016, te 5
      send(9'h016, 6'd5);
      @(negedge clk);
      chk("latency_c1", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_c2", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;

      // Zero, underflow, carry-set corner cases back to back
      send(9'h000, 6'h3D);
      send(9'h001, 6'h22);
      send(9'h100, 6'd4);
      drain();

      // Backpressure: two accepts fill the pipe, then input stalls
      forced_ready = 1'b0;
      send(9'h0F3, 6'd10);
      send(9'h02A, 6'h3E);
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      fork
         begin
            send(9'h004, 6'h21);
            send(9'h1FF, 6'd31);
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            forced_ready = 1'b1;
         end
      join
      drain();

      // Reset with both stages holding data
      forced_ready = 1'b0;
      send(9'h055, 6'd3);
      send(9'h0AA, 6'd7);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_mant", 32'(out_mant), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      forced_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stale_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Randomised traffic with random downstream backpressure
      rand_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end else begin
            case ($urandom_range(0, 4))
               0: rm = 9'h000;
               1: rm = 9'h100 | 9'($urandom_range(0, 255));
               2: rm = 9'($urandom_range(0, 3));
               default: rm = 9'($urandom_range(0, 511));
            endcase
            send(rm, 6'($urandom_range(0, 63)));
         end
      end
      rand_mode = 1'b0;
      forced_ready = 1'b1;
      @(posedge clk);
      #1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_core_sub_norm_pipe
